lfsr_stream_deser: RTL and testbench
====================================

Name: lfsr_stream_deser

Overview:
- Downstream stage for the LFSR pattern unit.
- Consumes its serial, LSB-first bit stream (OUT/Valid) and reassembles it into parallel words.
- Hands each completed word to the next consumer through a single-entry valid/ready holding register.
- Reports words that had to be dropped because the consumer was stalled.

Parameters:
- DATA_WIDTH, 8: bits per assembled word (legal range 2..32).
- CNT_WIDTH, 6: width of bit_count; must satisfy 2^CNT_WIDTH > DATA_WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial data bit from the LFSR stage (its OUT).
- bit_valid  input  1  stream-valid level from the LFSR stage (its Valid).
- sample_en  input  1  high for exactly one cycle per new bit; integration drives it from the LFSR output-shift enable, delayed one cycle.
- flush  input  1  synchronous abort of a partially collected word.
- data_ready  input  1  downstream consumer accepts data_out.
- clr_overrun  input  1  synchronous clear of the sticky overrun flag.
- data_out  output  DATA_WIDTH  assembled word.
- data_valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky flag: a completed word was dropped.
- bit_count  output  CNT_WIDTH  number of bits collected in the current word.
- parity_err  output  1  parity result of the word in data_out (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous): shift register = 0, bit_count = 0, data_out = 0, data_valid = 0, overrun = 0, parity_err = 0, FSM = IDLE.
- Reset asserted mid-word or mid-handshake discards everything immediately; no word is emitted after release.
- Accepted sample: sample_en && bit_valid && !flush at a rising edge. sample_en is ignored while bit_valid is low, and bit_count is retained across such gaps.
- Bit order is LSB first: on each accepted sample, sr <= {bit_in, sr[DATA_WIDTH-1:1]} and bit_count increments.
- FSM states: IDLE (bit_count = 0), COLLECT (0 < bit_count < FRAME_LEN).
  - IDLE -> COLLECT on an accepted sample.
  - COLLECT -> IDLE on flush, or on the FRAME_LEN-th accepted sample.
- FRAME_LEN = DATA_WIDTH (DATA_WIDTH+1 with the optional feature).
- Completing sample (the FRAME_LEN-th):
  - bit_count returns to 0.
  - The word, including the bit arriving that cycle, is offered to the holding register.
- Holding register load: if data_valid = 0, or data_valid && data_ready in the same cycle, then data_out <= word and data_valid = 1 from the next cycle. Latency is 1 clk from the completing sample to data_valid.
- Holding register full and not draining: the completed word is discarded, data_out is unchanged and overrun <= 1.
- Handshake:
  - A word transfers on any edge where data_valid && data_ready.
  - data_valid deasserts the next cycle unless a new word loads that same edge, in which case it stays high with the new data.
  - data_out and data_valid are stable while data_ready is low.
- overrun is sticky and clears only on clr_overrun or reset. If clr_overrun coincides with a new drop, set wins (overrun = 1).
- flush: clears sr and bit_count; the holding register is untouched. flush coinciding with sample_en discards that sample.
- bit_count never exceeds FRAME_LEN-1 while observable.

Optional Feature:
- Macro: LFSR_DESER_PARITY_EN.
- Defined:
  - FRAME_LEN = DATA_WIDTH+1; the final bit received is an even-parity bit over the data bits and is not stored in data_out.
  - parity_err loads together with data_out: 1 if XOR of data bits and parity bit is 1.
  - parity_err clears when data_valid deasserts.
- Undefined: FRAME_LEN = DATA_WIDTH and parity_err is constant 0. The port is always present.

Test Plan:
- Basic word: DATA_WIDTH=8, data_ready=1, send bits 1,0,1,0,0,1,0,1 on consecutive samples -> data_out=0xA5, data_valid high for exactly 1 cycle, 1 clk after the 8th sample; overrun=0.
- Gaps: send 0x3C with sample_en low for 2 cycles between bits and bit_valid dropped for 3 cycles mid-word -> data_out=0x3C; bit_count holds during the gaps.
- Back-pressure: data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Then data_ready=1 -> 0x11 drains. Pulse clr_overrun -> overrun=0.
- Drain and load same edge: data_out=0x55 valid, completing sample of 0xAA with data_ready=1 -> data_valid stays high, data_out=0xAA next cycle, overrun=0.
- Flush and reset: 3 bits then flush, then 0xF0 -> data_out=0xF0. Separately, 5 bits then rst low for 1 cycle, then 0x0F -> data_out=0x0F and no spurious word.
- Parity (macro defined): 0xA5 + parity bit 0 -> parity_err=0; 0xA5 + parity bit 1 -> parity_err=1, data_out=0xA5.

Source files
------------

// File: rtl/lfsr_stream_deser_if.sv
// ---------------------------------------------------------------------------
// lfsr_stream_deser_if
//   Word-output handshake bundle for lfsr_stream_deser.
//
//   Signals:
//     data_out    DATA_WIDTH  assembled word (producer -> consumer)
//     data_valid  1           data_out holds an unconsumed word
//     data_ready  1           consumer accepts data_out this cycle
//
//   Modports:
//     master  the deserializer (drives data_out/data_valid)
//     slave   the downstream consumer (drives data_ready)
// ---------------------------------------------------------------------------
interface lfsr_stream_deser_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/lfsr_stream_deser.sv
// ---------------------------------------------------------------------------
// lfsr_stream_deser
//   Reassembles the LSB-first serial stream of the LFSR pattern unit into
//   parallel words and hands each word to the consumer through a
//   single-entry valid/ready holding register. Words that complete while the
//   holding register is full and not draining are dropped and flagged on the
//   sticky overrun output.
//
//   Optional feature (macro LFSR_DESER_PARITY_EN):
//     Each frame carries one extra trailing even-parity bit. The parity bit
//     is not stored; parity_err reports the check result for the word in
//     data_out. Without the macro parity_err is tied low.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous, active-low reset
//     bit_in       serial data bit from the LFSR stage
//     bit_valid    stream-valid level from the LFSR stage
//     sample_en    one-cycle strobe per new bit
//     flush        synchronous abort of the partially collected word
//     clr_overrun  synchronous clear of the sticky overrun flag
//     bit_count    bits collected so far in the current word
//     overrun      sticky: a completed word was dropped
//     parity_err   parity result of the word in data_out
//     bus          master side of the word handshake (data_out,
//                  data_valid, data_ready)
// ---------------------------------------------------------------------------
module lfsr_stream_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 sample_en,
    input  logic                 flush,
    input  logic                 clr_overrun,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic                 overrun,
    output logic                 parity_err,
    lfsr_stream_deser_if.master  bus
);

`ifdef LFSR_DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif

    // Only FRAME_LEN-1 bits need storing: the last bit of a frame is taken
    // straight from bit_in on the completing sample.
    localparam int SR_W = FRAME_LEN - 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                state;
    logic [SR_W-1:0]       sr;
    logic [FRAME_LEN-1:0]  frame;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;
    logic                  completing;
    logic                  load_ok;
    logic                  xfer;

    assign accept     = sample_en && bit_valid && !flush;
    assign frame      = {bit_in, sr};
    assign completing = accept && (bit_count == LAST_IDX);
    assign xfer       = bus.data_valid && bus.data_ready;
    assign load_ok    = !bus.data_valid || bus.data_ready;
    assign word       = frame[DATA_WIDTH-1:0];

    // Collection FSM: shift register, bit counter and state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_count <= '0;
        end else if (flush) begin
            state     <= IDLE;
            sr        <= '0;
            bit_count <= '0;
        end else if (accept) begin
            sr <= frame[FRAME_LEN-1:1];
            case (state)
                IDLE: begin
                    bit_count <= CNT_WIDTH'(1);
                    state     <= COLLECT;
                end
                COLLECT: begin
                    if (bit_count == LAST_IDX) begin
                        bit_count <= '0;
                        state     <= IDLE;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                    end
                end
                default: begin
                    bit_count <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Single-entry holding register with sticky drop flag. A load and a
    // drain on the same edge keep data_valid high with the new word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (completing && load_ok) begin
                bus.data_out   <= word;
                bus.data_valid <= 1'b1;
            end else if (xfer) begin
                bus.data_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (completing && !load_ok) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef LFSR_DESER_PARITY_EN
    logic perr_q;

    // Even parity over data plus parity bit: any odd total is an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else if (completing && load_ok) begin
            perr_q <= ^frame;
        end else if (xfer) begin
            perr_q <= 1'b0;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_deser.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_deser
//   Self-checking bench for lfsr_stream_deser (DATA_WIDTH=8). Stimulus tasks
//   push the expected word into a queue as each frame is issued; a monitor
//   pops and compares whenever a word is transferred on the handshake.
//   Works with or without LFSR_DESER_PARITY_EN defined.
// ---------------------------------------------------------------------------
module tb_lfsr_stream_deser;

`ifdef LFSR_DESER_PARITY_EN
    localparam int FRAME_LEN = 9;
    localparam bit PAR_EN    = 1'b1;
`else
    localparam int FRAME_LEN = 8;
    localparam bit PAR_EN    = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sample_en;
    logic       flush;
    logic       clr_overrun;
    logic [5:0] bit_count;
    logic       overrun;
    logic       parity_err;

    int passed = 0;
    int total  = 0;
    exp_t exp_q[$];

    lfsr_stream_deser_if #(.DATA_WIDTH(8)) bus ();

    lfsr_stream_deser #(.DATA_WIDTH(8), .CNT_WIDTH(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .sample_en   (sample_en),
        .flush       (flush),
        .clr_overrun (clr_overrun),
        .bit_count   (bit_count),
        .overrun     (overrun),
        .parity_err  (parity_err),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    // Frame = 8 data bits plus an even-parity bit (inverted when flip=1).
    function automatic logic [8:0] frame_of(input logic [7:0] w, input logic flip);
        return {(^w) ^ flip, w};
    endfunction

    task automatic send_range(input logic [8:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(f[i]);
    endtask

    task automatic expect_word(input logic [7:0] w, input logic flip);
        exp_q.push_back('{data: w, perr: PAR_EN & flip});
    endtask

    task automatic send_word(input logic [7:0] w, input logic flip);
        send_range(frame_of(w, flip), 0, FRAME_LEN - 1);
    endtask

    // Monitor: every transferred word must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.data_valid && bus.data_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL spurious_word: got data_out=0x%0h, expected no word", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(bus.data_out), 32'(e.data));
                    check("word_parity", 32'(parity_err), 32'(e.perr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [8:0] f;
        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sample_en = 1'b0;
        flush = 1'b0; clr_overrun = 1'b0; bus.data_ready = 1'b1;
        #1;
        check("rst_data_valid", 32'(bus.data_valid), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_bit_count", 32'(bit_count), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Basic word, consumer always ready: valid for exactly one cycle.
        expect_word(8'hA5, 1'b0);
        send_word(8'hA5, 1'b0);
        check("basic_valid", 32'(bus.data_valid), 1);
        check("basic_data", 32'(bus.data_out), 32'hA5);
        tick();
        check("basic_one_cycle", 32'(bus.data_valid), 0);
        check("basic_overrun", 32'(overrun), 0);

        // Gaps: idle strobes between bits, bit_valid low mid-word.
        expect_word(8'h3C, 1'b0);
        f = frame_of(8'h3C, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            send_bit(f[i]);
            if (i == 3) begin
                bit_valid = 1'b0;
                sample_en = 1'b1;
                repeat (3) tick();
                sample_en = 1'b0;
                bit_valid = 1'b1;
                check("gap_count_hold", 32'(bit_count), 4);
            end else begin
                repeat (2) tick();
            end
        end
        tick();

        // Back-pressure: second word dropped, set beats clear, then drain.
        bus.data_ready = 1'b0;
        expect_word(8'h11, 1'b0);
        send_word(8'h11, 1'b0);
        check("bp_first_valid", 32'(bus.data_valid), 1);
        send_word(8'h22, 1'b0);
        check("bp_hold_data", 32'(bus.data_out), 32'h11);
        check("bp_overrun_set", 32'(overrun), 1);
        f = frame_of(8'h33, 1'b0);
        send_range(f, 0, FRAME_LEN - 2);
        clr_overrun = 1'b1;
        send_bit(f[FRAME_LEN-1]);
        clr_overrun = 1'b0;
        check("bp_set_wins", 32'(overrun), 1);
        check("bp_hold_data2", 32'(bus.data_out), 32'h11);
        bus.data_ready = 1'b1;
        tick();
        check("bp_drained", 32'(bus.data_valid), 0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("bp_overrun_clr", 32'(overrun), 0);

        // Drain and load on the same edge.
        bus.data_ready = 1'b0;
        expect_word(8'h55, 1'b0);
        send_word(8'h55, 1'b0);
        expect_word(8'hAA, 1'b0);
        f = frame_of(8'hAA, 1'b0);
        send_range(f, 0, FRAME_LEN - 2);
        bus.data_ready = 1'b1;
        send_bit(f[FRAME_LEN-1]);
        check("dl_valid_stays", 32'(bus.data_valid), 1);
        check("dl_new_data", 32'(bus.data_out), 32'hAA);
        check("dl_overrun", 32'(overrun), 0);
        tick();

        // Flush mid-word; the coincident sample is discarded.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        flush = 1'b1; sample_en = 1'b1; bit_in = 1'b1;
        tick();
        flush = 1'b0; sample_en = 1'b0;
        check("flush_count", 32'(bit_count), 0);
        expect_word(8'hF0, 1'b0);
        send_word(8'hF0, 1'b0);
        tick();

        // Reset mid-word discards the partial word.
        repeat (5) send_bit(1'b1);
        rst = 1'b0;
        #1;
        check("midrst_count", 32'(bit_count), 0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("midrst_no_word", 32'(bus.data_valid), 0);
        expect_word(8'h0F, 1'b0);
        send_word(8'h0F, 1'b0);
        tick();

        // Parity: good, then bad parity bit (error only when feature enabled).
        expect_word(8'hA5, 1'b0);
        send_word(8'hA5, 1'b0);
        expect_word(8'hA5, 1'b1);
        send_word(8'hA5, 1'b1);
        tick();
        check("perr_clears", 32'(parity_err), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
